// File: rtl/nx_ram_1r1w_rd_eng_if.sv
// Read-data stream out of the circular-buffer read engine; master drives data, slave drives ready.
// Latency/backpressure are owned by the engine: rd_dat is held while rd_vld=1 and rd_rdy=0.
interface nx_ram_1r1w_rd_eng_if #(
  parameter int WIDTH = 83
) ();
  logic             rd_vld;
  logic             rd_rdy;
  logic [WIDTH-1:0] rd_dat;

  modport master (output rd_vld, output rd_dat, input rd_rdy);
  modport slave  (input rd_vld, input rd_dat, output rd_rdy);
endinterface

// File: rtl/nx_ram_1r1w_rd_eng.sv
// In-order RAM read issue behind the writer commit pointer; data out RD_LAT+1 cycles after issue.
// A credited skid FIFO absorbs read latency, so issue stops (never drops data) when rd_rdy is low.
module nx_ram_1r1w_rd_eng #(
  parameter int WIDTH      = 83,
  parameter int DEPTH      = 168,
  parameter int AW         = 8,
  parameter int RD_LAT     = 2,
  parameter int SKID_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [AW:0]          wr_ptr,
  output logic [AW:0]          rd_ptr,
  output logic                 reb,
  output logic [AW-1:0]        ra,
  input  logic [WIDTH-1:0]     dout,
  nx_ram_1r1w_rd_eng_if.master rd_if,
  output logic                 empty
);
  localparam int SW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [AW:0]       iss_ptr_q, iss_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     ra_q, ra_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic [WIDTH-1:0]  skid_q [SKID_DEPTH];
  logic [SW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     occ;
  logic              issue, push, pop, ptr_ok;

  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) return {~p[AW], {AW{1'b0}}};
    return {p[AW], p[AW-1:0] + AW'(1)};
  endfunction

  function automatic logic [SW-1:0] skid_inc(input logic [SW-1:0] p);
    if (p == SW'(SKID_DEPTH - 1)) return '0;
    return p + SW'(1);
  endfunction

  assign pop  = rd_if.rd_vld & rd_if.rd_rdy & ~clr;
  assign push = tag_q[RD_LAT-1] & ~clr;

  // The word leaving this cycle frees its slot now, which keeps issue at one per cycle.
  always_comb begin
    occ = OW'(cnt_q);
    for (int i = 0; i < RD_LAT; i++) occ = occ + OW'(tag_q[i]);
    if (pop) occ = occ - OW'(1);
  end

  always_comb begin
    issue     = (iss_ptr_q != wr_ptr) && (occ < OW'(SKID_DEPTH)) && !clr;
    iss_ptr_d = iss_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ra_d      = ra_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    tag_d[0]  = issue;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    if (issue) begin
      iss_ptr_d = ptr_inc(iss_ptr_q);
      ra_d      = iss_ptr_q[AW-1:0];
    end
    if (push) wp_d = skid_inc(wp_q);
    if (pop) begin
      rp_d     = skid_inc(rp_q);
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
    // Flush: drop everything in flight and restart from the writer's pointer.
    if (clr) begin
      iss_ptr_d = wr_ptr;
      rd_ptr_d  = wr_ptr;
      tag_d     = '0;
      wp_d      = '0;
      rp_d      = '0;
      cnt_d     = '0;
    end
  end

  assign reb          = ~issue;
  assign ra           = issue ? iss_ptr_q[AW-1:0] : ra_q;
  assign rd_ptr       = rd_ptr_q;
  assign empty        = (rd_ptr_q == wr_ptr);
  assign rd_if.rd_vld = (cnt_q != '0);
  assign rd_if.rd_dat = skid_q[rp_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_ptr_q <= '0;
      rd_ptr_q  <= '0;
      ra_q      <= '0;
      tag_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) skid_q[i] <= '0;
    end else begin
      iss_ptr_q <= iss_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ra_q      <= ra_d;
      tag_q     <= tag_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      if (push) skid_q[wp_q] <= dout;
    end
  end

  assign ptr_ok = (wr_ptr[AW] == rd_ptr_q[AW]) ? (wr_ptr[AW-1:0] >= rd_ptr_q[AW-1:0])
                                               : (wr_ptr[AW-1:0] <= rd_ptr_q[AW-1:0]);

  always_ff @(posedge clk) begin
    if (rst_n && !clr) begin
      a_wr_ptr_range: assert (ptr_ok);
      a_skid_no_ovf:  assert (!push || pop || (cnt_q < CW'(SKID_DEPTH)));
    end
  end
endmodule

// File: tb/tb_nx_ram_1r1w_rd_eng.sv
// Bench for the read engine: behavioural 2-cycle RAM, address and data scoreboards fed at commit time.
module tb_nx_ram_1r1w_rd_eng;
  localparam int WIDTH      = 83;
  localparam int DEPTH      = 168;
  localparam int AW         = 8;
  localparam int RD_LAT     = 2;
  localparam int SKID_DEPTH = 3;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             clr    = 1'b0;
  logic [AW:0]      wr_ptr = '0;
  logic [AW:0]      rd_ptr;
  logic             reb;
  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] dout   = '0;
  logic             empty;

  nx_ram_1r1w_rd_eng_if #(.WIDTH(WIDTH)) rd_if ();

  nx_ram_1r1w_rd_eng #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .RD_LAT(RD_LAT), .SKID_DEPTH(SKID_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .reb(reb), .ra(ra), .dout(dout), .rd_if(rd_if), .empty(empty)
  );

  always #5 clk = ~clk;

  // RAM model: input flop on reb/ra, output flop on data.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ram_a_q  = '0;
  logic             ram_en_q = 1'b0;
  always @(posedge clk) begin
    ram_en_q <= ~reb;
    ram_a_q  <= ra;
    if (ram_en_q) dout <= mem[ram_a_q];
  end

  logic [WIDTH-1:0] exp_dat[$];
  logic [AW-1:0]    exp_ra[$];
  int checks = 0, errors = 0;
  int cyc = 0, iss_cnt = 0, dlv_cnt = 0, first_iss = -1, first_vld = -1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW:0] inc(input logic [AW:0] p);
    logic [AW:0] r;
    if (int'(p[AW-1:0]) == DEPTH - 1) r = {~p[AW], {AW{1'b0}}};
    else                              r = p + (AW+1)'(1);
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!reb) begin
        iss_cnt++;
        if (first_iss < 0) first_iss = cyc;
        chk("ra_issue_expected", exp_ra.size() != 0, 1);
        if (exp_ra.size() != 0) chk("ra", ra, exp_ra.pop_front());
      end
      if (rd_if.rd_vld && first_vld < 0) first_vld = cyc;
      if (rd_if.rd_vld && rd_if.rd_rdy && !clr) begin
        dlv_cnt++;
        chk("dat_expected", exp_dat.size() != 0, 1);
        if (exp_dat.size() != 0) chk("rd_dat", rd_if.rd_dat, exp_dat.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic commit(input int n);
    for (int i = 0; i < n; i++) begin
      logic [WIDTH-1:0] d;
      d = WIDTH'({$urandom(), $urandom(), $urandom()});
      mem[wr_ptr[AW-1:0]] = d;
      exp_dat.push_back(d);
      exp_ra.push_back(wr_ptr[AW-1:0]);
      wr_ptr = inc(wr_ptr);
    end
  endtask

  task automatic flush_sb();
    exp_dat.delete();
    exp_ra.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_dat.size() != 0 || rd_if.rd_vld) && n < budget) begin
      step(1);
      n++;
    end
    chk({tag, "_drained"}, exp_dat.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rd_if.rd_rdy = 1'b1;
    #2;
    chk("rst_reb", reb, 1);
    chk("rst_ra", ra, 0);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_rd_vld", rd_if.rd_vld, 0);
    chk("rst_rd_dat", rd_if.rd_dat, 0);
    chk("rst_empty", empty, 1);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Basic burst and latency
    iss_cnt = 0; first_iss = -1; first_vld = -1;
    commit(4);
    step(4);
    chk("t1_issue_burst", iss_cnt, 4);
    chk("t1_latency", first_vld - first_iss, RD_LAT + 1);
    drain("t1", 20);
    chk("t1_rd_ptr", rd_ptr, 4);
    chk("t1_empty", empty, 1);

    // Wrap across DEPTH-1
    clr = 1'b1; wr_ptr = (AW+1)'(166); flush_sb();
    step(1);
    clr = 1'b0;
    chk("t2_resync_ptr", rd_ptr, 166);
    commit(4);
    drain("t2", 20);
    chk("t2_rd_ptr", rd_ptr, 9'h102);

    // Stall then release
    rd_if.rd_rdy = 1'b0; iss_cnt = 0;
    commit(10);
    step(4);
    chk("t3_vld_stall", rd_if.rd_vld, 1);
    chk("t3_dat_hold_a", rd_if.rd_dat, exp_dat[0]);
    step(4);
    chk("t3_issued", iss_cnt, SKID_DEPTH);
    chk("t3_dat_hold_b", rd_if.rd_dat, exp_dat[0]);
    rd_if.rd_rdy = 1'b1; dlv_cnt = 0;
    step(10);
    chk("t3_no_bubble", dlv_cnt, 10);
    drain("t3", 20);
    chk("t3_rd_ptr", rd_ptr, 9'h10C);

    // Full buffer
    commit(DEPTH);
    chk("t4_full_ptr", wr_ptr, 9'h00C);
    drain("t4", 400);
    chk("t4_rd_ptr", rd_ptr, 9'h00C);
    chk("t4_empty", empty, 1);

    // Flush with reads in flight
    rd_if.rd_rdy = 1'b0;
    commit(10);
    step(3);
    clr = 1'b1; wr_ptr = (AW+1)'(20); flush_sb();
    step(1);
    clr = 1'b0;
    chk("t5_vld_after_clr", rd_if.rd_vld, 0);
    chk("t5_rd_ptr", rd_ptr, 20);
    chk("t5_empty", empty, 1);
    rd_if.rd_rdy = 1'b1; dlv_cnt = 0;
    step(5);
    chk("t5_no_stale", dlv_cnt, 0);
    commit(5);
    drain("t5", 20);
    chk("t5_rd_ptr_end", rd_ptr, 25);

    // Async reset mid-burst
    commit(8);
    step(3);
    #2;
    rst_n = 1'b0; wr_ptr = '0; flush_sb();
    #1;
    chk("t6_rst_reb", reb, 1);
    chk("t6_rst_ra", ra, 0);
    chk("t6_rst_rd_ptr", rd_ptr, 0);
    chk("t6_rst_rd_vld", rd_if.rd_vld, 0);
    chk("t6_rst_rd_dat", rd_if.rd_dat, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    commit(3);
    #1;
    chk("t6_first_reb", reb, 0);
    chk("t6_first_ra", ra, 0);
    drain("t6", 20);
    chk("t6_rd_ptr", rd_ptr, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
